alu_accum_sequencer: RTL and testbench
======================================

// Module: alu_accum_sequencer
// PURPOSE
//  Sequences the 64-bit logic ALU (modes 0: a^b, 1: ~a&b, 2: ~a) over a stream of operand words.
//  A start command sets a seed, an op mode and a beat count. Each accepted beat updates the
//  accumulator: acc <= ALU(a=acc, b=in_data, mode).
//  The final accumulator is returned over a valid/ready result port.
//  Sits between the key/mask loading logic and the ALU instance, which it owns.
// PARAMETERS
//  WIDTH  64  datapath width; fixed at 64 to match the ALU
//  CNT_W  8   width of the beat-count field len
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      command strobe; sampled only in IDLE
//  len       in   CNT_W  number of operand beats (0 allowed)
//  init      in   WIDTH  accumulator seed
//  op_mode   in   2      ALU mode for the whole transaction
//  abort     in   1      synchronous cancel of a RUN transaction
//  in_valid  in   1      operand beat valid
//  in_data   in   WIDTH  operand word (ALU b input)
//  in_ready  out  1      sequencer accepts an operand this cycle
//  out_valid out  1      result valid
//  out_data  out  WIDTH  final accumulator value
//  out_ready in   1      result consumer ready
//  busy      out  1      high in RUN or DONE
//  err       out  1      one-cycle pulse: start rejected
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; acc, cnt, mode_r = 0.
//   in_ready, out_valid, busy, err = 0; out_data = 0.
//  States: IDLE, RUN, DONE. The ALU is instantiated combinationally: a=acc, b=in_data, mode=mode_r.
//  IDLE:
//   - start & op_mode==3: err=1 for one cycle; stay in IDLE; acc is unchanged.
//   - start & len==0: acc<=init, go to DONE. No beats are requested.
//   - start & len!=0: acc<=init, mode_r<=op_mode, cnt<=len, go to RUN.
//   - start with any other state: ignored, no err.
//  RUN:
//   - in_ready=1 (registered state decode, not dependent on in_valid).
//   - Beat = in_valid & in_ready. On a beat: acc<=ALU y; cnt<=cnt-1.
//   - Beat with cnt==1: go to DONE on the same edge.
//   - No beat: hold acc and cnt. Stalls of any length are legal.
//   - abort: go to IDLE and discard acc. abort wins over a simultaneous beat, and no result is produced.
//  DONE:
//   - out_valid=1; out_data=acc; in_ready=0.
//   - On out_valid & out_ready: go to IDLE.
//   - Under backpressure, hold out_valid and out_data stable. abort is ignored.
//  Latency: out_valid rises the cycle after the last beat, or the cycle after start when len==0.
//  Throughput: one beat per clock; a new start is accepted the cycle after the result handshake.
//  out_data is 0 whenever out_valid=0. busy = (state != IDLE).
//  Mode 2 ignores in_data, but beats are still consumed and counted.
//  Arithmetic: pure bitwise, no carries. cnt is never decremented below 0.
// TESTING
//  T1 init=0, mode0, len=3, data 0x1,0x2,0x4 back-to-back -> out_data=0x7; out_valid 1 cycle after beat 3.
//  T2 init=0x0F, mode1, len=1, data=0xFF -> out_data=0xF0. Repeat with in_valid gaps of 5 cycles -> same result.
//  T3 init=0, mode2, len=1 -> 0xFFFF_FFFF_FFFF_FFFF. len=2 -> 0x0. Both with in_data=random.
//  T4 len=0, init=0xDEAD -> in_ready never high; out_valid next cycle, out_data=0xDEAD.
//     Hold out_ready=0 for 4 cycles -> out_data stable.
//  T5 start with op_mode=3 -> err pulses 1 cycle, busy=0. Abort after 1 of 3 beats -> IDLE, no out_valid.
//  T6 rst asserted mid-RUN between clock edges -> all outputs 0 immediately. Next start (T1 stimulus) -> 0x7.

Source files
------------

// File: rtl/alu_accum_sequencer_if.sv
// Command, operand-stream and result bundle between the loader and the sequencer.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; the sequencer owns in_ready.
//
// Ports (by modport):
//   master drives : start, len, init, op_mode, abort, in_valid, in_data, out_ready
//   master samples: in_ready, out_valid, out_data, busy, err
//   slave is the mirror of master and is used by the sequencer.
interface alu_accum_sequencer_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] init;
    logic [1:0]       op_mode;
    logic             abort;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             busy;
    logic             err;

    modport master (
        output start, len, init, op_mode, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, err
    );

    modport slave (
        input  start, len, init, op_mode, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, err
    );
endinterface

// File: rtl/alu_accum_sequencer.sv
// Folds a stream of operand words into an accumulator through a 64-bit bitwise ALU.
// Latency: result valid the cycle after the last beat (cycle after start when len==0).
// Backpressure: in_ready high only in RUN; result held stable in DONE until out_ready.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of alu_accum_sequencer_if (command, operand stream, result, status)

// Pure bitwise ALU: 0: a^b, 1: ~a&b, 2: ~a. Mode 3 is never selected by the sequencer.
module logic_alu #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (mode)
            2'd0:    y = a ^ b;
            2'd1:    y = ~a & b;
            2'd2:    y = ~a;
            default: y = '0;
        endcase
    end
endmodule

module alu_accum_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    alu_accum_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_y;
    logic             beat;

    logic_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (acc_q),
        .b    (bus.in_data),
        .mode (mode_q),
        .y    (alu_y)
    );

    // in_ready is a pure state decode so it never combinationally depends on in_valid.
    assign beat = bus.in_valid && (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op_mode == 2'd3) begin
                        // Illegal mode: flag it and leave the accumulator untouched.
                        err_d = 1'b1;
                    end else begin
                        acc_d   = bus.init;
                        mode_d  = bus.op_mode;
                        cnt_d   = bus.len;
                        state_d = (bus.len == '0) ? S_DONE : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    // Abort beats a simultaneous beat; the partial result is dropped.
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (beat && (cnt_q != '0)) begin
                    acc_d = alu_y;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // All outputs decode registered state, so an async reset clears them at once.
    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = (state_q == S_DONE) ? acc_q : '0;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_accum_sequencer.sv
// Directed self-checking bench for alu_accum_sequencer.
// Latency: inputs driven 1ns after the rising edge, outputs sampled there or mid-cycle.
// Backpressure: exercises operand stalls and result backpressure.
module tb_alu_accum_sequencer;
    localparam int WIDTH = 64;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_accum_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_accum_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a one-cycle start command; returns 1ns after the accepting edge.
    task automatic start_cmd(input logic [WIDTH-1:0] init, input logic [CNT_W-1:0] len,
                             input logic [1:0] mode);
        bus.start   = 1'b1;
        bus.init    = init;
        bus.len     = len;
        bus.op_mode = mode;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] data);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Pops the held result with one handshake cycle.
    task automatic pop_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.init = '0; bus.op_mode = '0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #12;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.in_ready, bus.out_valid, bus.busy, bus.err});
        end
        checks++;
        if (bus.out_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    // init=0, mode 0, beats 1,2,4 back-to-back -> 0x7 one cycle after beat 3.
    task automatic run_xor_stream(input string tag);
        start_cmd(64'h0, 8'd3, 2'd0);
        send_beat(64'h1);
        send_beat(64'h2);
        checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b110) begin
            failures++;
            $display("FAIL %s_mid_run: got rdy/busy/vld=%b expected 110", tag,
                     {bus.in_ready, bus.busy, bus.out_valid});
        end
        send_beat(64'h4);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h7 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_result: got vld=%b rdy=%b data=%h expected vld=1 rdy=0 data=7",
                     tag, bus.out_valid, bus.in_ready, bus.out_data);
        end
        pop_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 64'h0) begin
            failures++;
            $display("FAIL %s_after_pop: got vld=%b busy=%b data=%h expected 0 0 0",
                     tag, bus.out_valid, bus.busy, bus.out_data);
        end
    endtask

    task automatic test_back_to_back();
        run_xor_stream("xor_b2b");
    endtask

    task automatic test_andn();
        logic stall_bad;
        start_cmd(64'h0F, 8'd1, 2'd1);
        send_beat(64'hFF);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hF0) begin
            failures++;
            $display("FAIL andn_result: got vld=%b data=%h expected vld=1 data=f0",
                     bus.out_valid, bus.out_data);
        end
        pop_result();
        // Same transaction with a 5-cycle stall before the beat.
        start_cmd(64'h0F, 8'd1, 2'd1);
        stall_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) stall_bad = 1'b1;
            step();
        end
        checks++;
        if (stall_bad !== 1'b0) begin
            failures++;
            $display("FAIL andn_stall_hold: got bad=%b expected 0", stall_bad);
        end
        send_beat(64'hFF);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hF0) begin
            failures++;
            $display("FAIL andn_gap_result: got vld=%b data=%h expected vld=1 data=f0",
                     bus.out_valid, bus.out_data);
        end
        pop_result();
    endtask

    task automatic test_not();
        start_cmd(64'h0, 8'd1, 2'd2);
        send_beat({$urandom, $urandom});
        checks++;
        if (bus.out_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL not_len1: got %h expected ffffffffffffffff", bus.out_data);
        end
        pop_result();
        start_cmd(64'h0, 8'd2, 2'd2);
        send_beat({$urandom, $urandom});
        send_beat({$urandom, $urandom});
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0) begin
            failures++;
            $display("FAIL not_len2: got vld=%b data=%h expected vld=1 data=0",
                     bus.out_valid, bus.out_data);
        end
        pop_result();
    endtask

    task automatic test_len_zero();
        logic moved;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h1234;
        start_cmd(64'hDEAD, 8'd0, 2'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hDEAD || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL len0_result: got vld=%b rdy=%b data=%h expected vld=1 rdy=0 data=dead",
                     bus.out_valid, bus.in_ready, bus.out_data);
        end
        moved = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hDEAD || bus.in_ready !== 1'b0)
                moved = 1'b1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (moved !== 1'b0) begin
            failures++;
            $display("FAIL len0_backpressure_hold: got changed=%b expected 0", moved);
        end
        pop_result();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL len0_pop: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_err_abort();
        logic seen_vld;
        start_cmd(64'hAAAA, 8'd3, 2'd3);
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse: got err=%b busy=%b expected err=1 busy=0", bus.err, bus.busy);
        end
        step();
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL err_one_cycle: got err=%b expected 0", bus.err);
        end
        start_cmd(64'h0, 8'd3, 2'd0);
        send_beat(64'h8);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h5;
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b rdy=%b expected 0 0", bus.busy, bus.in_ready);
        end
        seen_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b0) seen_vld = 1'b1;
            step();
        end
        checks++;
        if (seen_vld !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_result: got out_valid seen=%b expected 0", seen_vld);
        end
        start_cmd(64'h30, 8'd1, 2'd0);
        send_beat(64'h03);
        checks++;
        if (bus.out_data !== 64'h33) begin
            failures++;
            $display("FAIL abort_then_new: got %h expected 33", bus.out_data);
        end
        pop_result();
    endtask

    task automatic test_async_reset();
        start_cmd(64'h0, 8'd3, 2'd0);
        send_beat(64'h1);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.err} !== 4'b0000 ||
            bus.out_data !== 64'h0) begin
            failures++;
            $display("FAIL async_reset: got flags=%b data=%h expected 0000 0",
                     {bus.in_ready, bus.out_valid, bus.busy, bus.err}, bus.out_data);
        end
        step();
        rst = 1'b0;
        step();
        run_xor_stream("after_reset");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_andn();
        test_not();
        test_len_zero();
        test_err_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop so a wedged run still terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000ns");
        $fatal(1, "timeout");
    end
endmodule
